// File: rtl/cmd_frame_parser.sv
// Length-delimited command-frame receiver: pulls one frame from a byte FIFO,
// checks header and trailing checksum, and unpacks NCMD command bytes.
module cmd_frame_parser #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned NCMD    = 9,
  parameter logic [15:0] HDR     = 16'h55AA,
  parameter bit          CHK_XOR = 1'b0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  output logic              fd,
  input  logic              fifo_empty,
  output logic              fifo_rxen,
  input  logic [7:0]        fifo_rxd,
  input  logic [7:0]        data_len,
  output logic [8*NCMD-1:0] cmd_out,
  output logic              cmd_valid,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt,
  output logic [7:0]        so
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [8:0]  LEN_MIN = 9'(NCMD + 3);
  localparam logic [8:0]  LEN_MAX = 9'(MAX_LEN);
  localparam logic [15:0] TO_LIM  = 16'(TIMEOUT);

  state_t            state_q;
  logic [7:0]        len_q;
  logic [7:0]        rd_cnt_q;
  logic [7:0]        wr_idx_q;
  logic [7:0]        acc_q;
  logic [7:0]        rx_chk_q;
  logic              hdr_bad_q;
  logic              rd_vld_q;
  logic [15:0]       to_cnt_q;
  logic [8*NCMD-1:0] shadow_q;
  logic [8*NCMD-1:0] cmd_out_q;
  logic              cmd_valid_q;
  logic              fd_q;
  logic              err_q;
  logic [2:0]        err_code_q;
  logic [15:0]       frame_cnt_q;
  logic [15:0]       err_cnt_q;

  logic              fin;
  logic [2:0]        fin_code;
  logic [7:0]        fold_byte;
  logic [7:0]        len_last;

  always_comb begin
    fifo_rxen = (state_q == READ) && !fifo_empty && (rd_cnt_q < len_q);
    fold_byte = CHK_XOR ? (acc_q ^ fifo_rxd) : (acc_q + fifo_rxd);
    len_last  = len_q - 8'd1;
  end

  // Every path into DONE (length, timeout, check) funnels through fin/fin_code.
  always_comb begin
    fin      = 1'b0;
    fin_code = 3'd0;
    case (state_q)
      LOAD: begin
        if (({1'b0, data_len} < LEN_MIN) || ({1'b0, data_len} > LEN_MAX)) begin
          fin      = 1'b1;
          fin_code = 3'd3;
        end
      end
      READ: begin
        if ((wr_idx_q != len_q) && (to_cnt_q == TO_LIM)) begin
          fin      = 1'b1;
          fin_code = 3'd4;
        end
      end
      CHECK: begin
        fin = 1'b1;
        if (hdr_bad_q)               fin_code = 3'd1;
        else if (acc_q != rx_chk_q)  fin_code = 3'd2;
        else                         fin_code = 3'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rd_cnt_q    <= '0;
      wr_idx_q    <= '0;
      acc_q       <= '0;
      rx_chk_q    <= '0;
      hdr_bad_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      to_cnt_q    <= '0;
      shadow_q    <= '0;
      cmd_out_q   <= '0;
      cmd_valid_q <= 1'b0;
      fd_q        <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      rd_vld_q    <= fifo_rxen;
      if (fifo_rxen) rd_cnt_q <= rd_cnt_q + 8'd1;

      case (state_q)
        IDLE: if (fs) state_q <= LOAD;
        LOAD: begin
          len_q      <= data_len;
          rd_cnt_q   <= '0;
          wr_idx_q   <= '0;
          acc_q      <= '0;
          hdr_bad_q  <= 1'b0;
          to_cnt_q   <= '0;
          err_q      <= 1'b0;
          err_code_q <= '0;
          if (!fin) state_q <= READ;
        end
        READ: begin
          if (wr_idx_q == len_q) begin
            state_q <= CHECK;
          end else if (!fin) begin
            if (rd_vld_q) begin
              to_cnt_q <= '0;
              wr_idx_q <= wr_idx_q + 8'd1;
              if (wr_idx_q == 8'd0) begin
                if (fifo_rxd != HDR[15:8]) hdr_bad_q <= 1'b1;
              end else if (wr_idx_q == 8'd1) begin
                if (fifo_rxd != HDR[7:0]) hdr_bad_q <= 1'b1;
              end else if (wr_idx_q == len_last) begin
                rx_chk_q <= fifo_rxd;
              end else begin
                acc_q <= fold_byte;
                for (int unsigned i = 0; i < NCMD; i++) begin
                  if (wr_idx_q == 8'(i + 2)) shadow_q[8*(NCMD-1-i) +: 8] <= fifo_rxd;
                end
              end
            end else begin
              to_cnt_q <= to_cnt_q + 16'd1;
            end
          end
        end
        CHECK: ;
        DONE: begin
          if (!fs) begin
            state_q <= IDLE;
            fd_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (fin) begin
        state_q    <= DONE;
        fd_q       <= 1'b1;
        err_code_q <= fin_code;
        if (fin_code == 3'd0) begin
          cmd_out_q   <= shadow_q;
          cmd_valid_q <= 1'b1;
          if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
          cmd_out_q <= '1;
          err_q     <= 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
      end
    end
  end

  always_comb begin
    fd        = fd_q;
    cmd_out   = cmd_out_q;
    cmd_valid = cmd_valid_q;
    err       = err_q;
    err_code  = err_code_q;
    frame_cnt = frame_cnt_q;
    err_cnt   = err_cnt_q;
    so        = {5'b0, state_q};
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: a sum-mode and an XOR-mode instance share one
// FIFO model; a frame-level reference model predicts every outcome.
module tb_cmd_frame_parser;
  localparam int unsigned NCMD    = 9;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned TOUT    = 8;
  localparam int unsigned CW      = 8 * NCMD;

  typedef logic [71:0] val_t;

  logic          clk = 1'b0;
  logic          rst, fs, fifo_empty;
  logic [7:0]    fifo_rxd, data_len;
  logic          fd_s, rxen_s, cv_s, err_s, fd_x, rxen_x, cv_x, err_x;
  logic [2:0]    ec_s, ec_x;
  logic [CW-1:0] cmd_s, cmd_x;
  logic [15:0]   fcnt_s, ecnt_s, fcnt_x, ecnt_x;
  logic [7:0]    so_s, so_x;

  always #5 clk = ~clk;

  cmd_frame_parser #(.MAX_LEN(MAX_LEN), .NCMD(NCMD), .HDR(16'h55AA), .CHK_XOR(1'b0), .TIMEOUT(TOUT)) u_sum (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd_s), .fifo_empty(fifo_empty), .fifo_rxen(rxen_s),
    .fifo_rxd(fifo_rxd), .data_len(data_len), .cmd_out(cmd_s), .cmd_valid(cv_s), .err(err_s),
    .err_code(ec_s), .frame_cnt(fcnt_s), .err_cnt(ecnt_s), .so(so_s));

  cmd_frame_parser #(.MAX_LEN(MAX_LEN), .NCMD(NCMD), .HDR(16'h55AA), .CHK_XOR(1'b1), .TIMEOUT(TOUT)) u_xor (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd_x), .fifo_empty(fifo_empty), .fifo_rxen(rxen_x),
    .fifo_rxd(fifo_rxd), .data_len(data_len), .cmd_out(cmd_x), .cmd_valid(cv_x), .err(err_x),
    .err_code(ec_x), .frame_cnt(fcnt_x), .err_cnt(ecnt_x), .so(so_x));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]    frm [0:255];
  logic [7:0]    fifo_q [$];
  int            stall_mode = 0;
  int            streak = 0;
  int            cyc = 0;
  int            rx_cnt = 0;
  int            last_rx_cyc = 0;
  int            fs_cyc = 0;
  int            cur_len = 0;
  bit            rxen_seen = 1'b0;
  bit            armed = 1'b0;
  int            exp_code [2];
  int            exp_reads;
  logic [CW-1:0] exp_cmd;
  logic [CW-1:0] mdl_cmd [2];
  int            mdl_fc [2];
  int            mdl_ec [2];
  bit            fd_prev [2];
  int            rise_cyc [2];

  task automatic check(input string name, input val_t act, input val_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: outcome of a frame from its bytes, length and how many bytes the FIFO supplies.
  function automatic int model_code(input int len, input int supply, input bit xmode);
    logic [7:0] acc;
    acc = 8'h00;
    if (len < int'(NCMD) + 3 || len > int'(MAX_LEN)) return 3;
    if (supply < len) return 4;
    if (frm[0] != 8'h55 || frm[1] != 8'hAA) return 1;
    for (int i = 2; i <= len - 2; i++) acc = xmode ? (acc ^ frm[i]) : (acc + frm[i]);
    return (acc == frm[len-1]) ? 0 : 2;
  endfunction

  task automatic cmp_dut(input int k, input logic fd, input logic cv, input logic er,
                         input logic [2:0] ec, input logic [CW-1:0] cmd,
                         input logic [15:0] fc, input logic [15:0] en, input logic [7:0] so);
    string p;
    logic  rise;
    int    er_cyc;
    p    = (k == 0) ? "sum" : "xor";
    rise = fd && !fd_prev[k];
    if (rise) begin
      rise_cyc[k] = cyc;
      check({p, "_fd_expected"}, val_t'(armed), val_t'(1));
      if (exp_code[k] == 0) begin
        mdl_cmd[k] = exp_cmd;
        if (mdl_fc[k] < 65535) mdl_fc[k]++;
      end else begin
        mdl_cmd[k] = '1;
        if (mdl_ec[k] < 65535) mdl_ec[k]++;
      end
      check({p, "_so_done"}, val_t'(so), val_t'(4));
      check({p, "_reads"}, val_t'(rx_cnt), val_t'(exp_reads));
      if (exp_code[k] == 3)      er_cyc = fs_cyc + 1;
      else if (exp_code[k] == 4) er_cyc = last_rx_cyc + int'(TOUT) + 2;
      else                       er_cyc = last_rx_cyc + 3;
      check({p, "_latency"}, val_t'(cyc), val_t'(er_cyc));
      if (exp_code[k] < 3 && stall_mode == 0)
        check({p, "_latency_fs"}, val_t'(cyc - fs_cyc), val_t'(cur_len + 4));
    end
    check({p, "_cmd_valid"}, val_t'(cv), val_t'(rise && exp_code[k] == 0));
    if (fd) begin
      check({p, "_err"}, val_t'(er), val_t'(exp_code[k] != 0));
      check({p, "_err_code"}, val_t'(ec), val_t'(exp_code[k]));
    end
    check({p, "_cmd_out"}, val_t'(cmd), val_t'(mdl_cmd[k]));
    check({p, "_frame_cnt"}, val_t'(fc), val_t'(mdl_fc[k]));
    check({p, "_err_cnt"}, val_t'(en), val_t'(mdl_ec[k]));
    fd_prev[k] = fd;
  endtask

  // FIFO model: data appears on fifo_rxd the cycle after a sampled read enable.
  initial begin : env
    logic [7:0] b;
    bit         popped;
    bit         st;
    fifo_empty = 1'b1;
    fifo_rxd   = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      popped = 1'b0;
      b      = 8'hEE;
      if (rxen_seen) begin
        rx_cnt++;
        last_rx_cyc = cyc;
        if (fifo_q.size() > 0) begin
          b      = fifo_q.pop_front();
          popped = 1'b1;
        end
      end
      #1;
      if (rxen_seen) fifo_rxd = popped ? b : 8'hEE;
      case (stall_mode)
        1:       st = (cyc % 4) != 0;
        2:       st = ($urandom_range(0, 1) == 1) && (streak < 3);
        default: st = 1'b0;
      endcase
      streak     = st ? streak + 1 : 0;
      fifo_empty = st || (fifo_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    rxen_seen = rxen_s;
    if (!rst) begin
      check("rxen_pair", val_t'(rxen_x), val_t'(rxen_s));
      check("rxen_when_empty", val_t'(rxen_s & fifo_empty), '0);
      cmp_dut(0, fd_s, cv_s, err_s, ec_s, cmd_s, fcnt_s, ecnt_s, so_s);
      cmp_dut(1, fd_x, cv_x, err_x, ec_x, cmd_x, fcnt_x, ecnt_x, so_x);
    end
  end

  task automatic chk_zero(input string tag);
    check({tag, "_fd"},   val_t'({fd_s, fd_x}), '0);
    check({tag, "_rxen"}, val_t'({rxen_s, rxen_x}), '0);
    check({tag, "_cmd_s"}, val_t'(cmd_s), '0);
    check({tag, "_cmd_x"}, val_t'(cmd_x), '0);
    check({tag, "_cv"},   val_t'({cv_s, cv_x}), '0);
    check({tag, "_err"},  val_t'({err_s, err_x}), '0);
    check({tag, "_ec"},   val_t'({ec_s, ec_x}), '0);
    check({tag, "_cnt"},  val_t'({fcnt_s, ecnt_s, fcnt_x, ecnt_x}), '0);
    check({tag, "_so"},   val_t'({so_s, so_x}), '0);
    for (int k = 0; k < 2; k++) begin
      mdl_cmd[k] = '0; mdl_fc[k] = 0; mdl_ec[k] = 0; fd_prev[k] = 1'b0;
    end
  endtask

  task automatic set_good();
    frm[0] = 8'h55; frm[1] = 8'hAA;
    for (int i = 0; i < 9; i++) frm[2+i] = 8'(i + 1);
    frm[11] = 8'h2D;
  endtask

  task automatic make_frame(input int len, input bit hdr_bad, input int kind);
    logic [7:0] s, x;
    s = 8'h00; x = 8'h00;
    frm[0] = 8'h55; frm[1] = 8'hAA;
    for (int i = 2; i <= len - 2; i++) begin
      frm[i] = 8'($urandom);
      s = s + frm[i];
      x = x ^ frm[i];
    end
    frm[len-1] = (kind == 0) ? s : (kind == 1) ? x : 8'($urandom);
    if (hdr_bad) frm[$urandom_range(0, 1)] ^= 8'($urandom_range(1, 255));
  endtask

  task automatic start_frame(input int len, input int supply, input int mode);
    int n;
    fifo_q.delete();
    n = (supply < len) ? supply : len;
    for (int i = 0; i < n; i++) fifo_q.push_back(frm[i]);
    exp_code[0] = model_code(len, supply, 1'b0);
    exp_code[1] = model_code(len, supply, 1'b1);
    exp_reads   = (exp_code[0] == 3) ? 0 : n;
    for (int i = 0; i < int'(NCMD); i++) exp_cmd[CW-1-8*i -: 8] = frm[2+i];
    stall_mode = mode;
    rx_cnt     = 0;
    @(posedge clk); #1;
    data_len = 8'(len);
    fs       = 1'b1;
    fs_cyc   = cyc + 1;
    cur_len  = len;
    armed    = 1'b1;
  endtask

  task automatic run_frame(input int len, input int supply, input int mode);
    int w;
    start_frame(len, supply, mode);
    w = 0;
    while (!fd_s && w < 1000) begin @(negedge clk); w++; end
    check("fd_rise_seen", val_t'(fd_s), val_t'(1));
    repeat (2) @(posedge clk);
    #1 fs = 1'b0;
    w = 0;
    while (fd_s && w < 20) begin @(negedge clk); w++; end
    check("fd_fall_seen", val_t'(fd_s), '0);
    armed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int len, supply;
    rst = 1'b1; fs = 1'b0; data_len = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    set_good();
    run_frame(12, 12, 0);
    check("good_cmd_lit", val_t'(cmd_s), 72'h010203040506070809);
    check("good_code_lit", val_t'(ec_s), '0);
    check("good_fcnt_lit", val_t'(fcnt_s), val_t'(1));
    check("good_lat_lit", val_t'(rise_cyc[0] - fs_cyc), val_t'(16));

    frm[0] = 8'h54;
    run_frame(12, 12, 0);
    check("hdr_code_lit", val_t'(ec_s), val_t'(1));
    check("hdr_reads_lit", val_t'(rx_cnt), val_t'(12));
    check("hdr_cmd_lit", val_t'(cmd_s), {72{1'b1}});
    check("hdr_ecnt_lit", val_t'(ecnt_s), val_t'(1));

    set_good(); frm[11] = 8'h2C;
    run_frame(12, 12, 0);
    check("chk_code_lit", val_t'(ec_s), val_t'(2));
    set_good();
    run_frame(12, 12, 0);
    check("good2_cmd_lit", val_t'(cmd_s), 72'h010203040506070809);
    check("good2_fcnt_lit", val_t'(fcnt_s), val_t'(2));

    run_frame(12, 12, 1);
    check("flow_cmd_lit", val_t'(cmd_s), 72'h010203040506070809);

    run_frame(12, 5, 0);
    check("to_code_lit", val_t'(ec_s), val_t'(4));
    check("to_lat_lit", val_t'(rise_cyc[0] - (last_rx_cyc + 1)), val_t'(9));

    run_frame(11, 11, 0);
    check("len_code_lit", val_t'(ec_s), val_t'(3));
    check("len_reads_lit", val_t'(rx_cnt), '0);

    frm[11] = 8'h01;
    run_frame(12, 12, 0);
    check("xor_code_lit", val_t'(ec_x), '0);
    check("xor_cmd_lit", val_t'(cmd_x), 72'h010203040506070809);

    // Reset in the middle of a frame.
    set_good();
    start_frame(12, 12, 0);
    begin
      int w;
      w = 0;
      while (rx_cnt < 6 && w < 200) begin @(negedge clk); w++; end
      check("abort_reach_byte6", val_t'(rx_cnt >= 6), val_t'(1));
    end
    @(posedge clk); #1;
    rst = 1'b1; fs = 1'b0; armed = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    run_frame(12, 12, 0);
    check("post_abort_cmd_lit", val_t'(cmd_s), 72'h010203040506070809);
    check("post_abort_fcnt_lit", val_t'(fcnt_s), val_t'(1));

    make_frame(32, 1'b0, 0);
    run_frame(32, 32, 2);
    check("maxlen_code_lit", val_t'(ec_s), '0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0)
        len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(4, 11)) : int'($urandom_range(33, 40));
      else
        len = int'($urandom_range(12, 32));
      supply = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, len - 1)) : len;
      make_frame(len, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)));
      run_frame(len, supply, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_frame_parser.md
Name: cmd_frame_parser

Overview:
- Parametrised command-frame receiver.
- Reads one length-delimited frame from a byte FIFO and validates a 16-bit header and a trailing checksum. Unpacks NCMD command bytes into a flat output bus.
- Sits between the command FIFO and the control-register bank.
- Adds the following relative to the fixed 9-byte generation:
  - FIFO-empty flow control;
  - streaming checksum in either sum or XOR mode;
  - length range check;
  - read timeout;
  - coded errors;
  - frame and error statistics counters.

Parameters:
MAX_LEN, 32, maximum frame length in bytes (header, payload and checksum); 4..255
NCMD, 9, number of command bytes unpacked from payload bytes 2..NCMD+1
HDR, 16'h55AA, required value of byte0 (MSB) and byte1
CHK_XOR, 0, 0 = 8-bit modular sum checksum, 1 = XOR checksum
TIMEOUT, 255, consecutive cycles with no byte accepted before the frame is aborted; 1..65535

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
fs  in  1  frame start request, level; held until fd
fd  out  1  frame done; high in DONE state
fifo_empty  in  1  source FIFO empty
fifo_rxen  out  1  FIFO read enable; data valid on fifo_rxd the following cycle
fifo_rxd  in  8  FIFO read data
data_len  in  8  frame length in bytes; sampled in LOAD
cmd_out  out  8*NCMD  command bytes; payload byte 2 lands in cmd_out[8*NCMD-1 -: 8], in descending order
cmd_valid  out  1  one-cycle pulse on entry to DONE for a good frame
err  out  1  sticky per frame; valid while fd is high
err_code  out  3  0 ok, 1 header, 2 checksum, 3 length, 4 timeout
frame_cnt  out  16  good frames, saturating at 16'hFFFF
err_cnt  out  16  errored frames, saturating at 16'hFFFF
so  out  8  current state code, for debug

Behaviour:
- Reset values: all outputs are 0; state is IDLE; internal counters and the checksum accumulator are 0.
- State codes: IDLE=0, LOAD=1, READ=2, CHECK=3, DONE=4. Any other state code goes to IDLE.
- IDLE: go to LOAD when fs=1.
- LOAD (1 cycle):
  - Latch len <= data_len.
  - Clear rd_cnt, wr_idx, the checksum accumulator, hdr_ok and the timeout counter.
  - If len < NCMD+3 or len > MAX_LEN, go to DONE with err_code=3; no FIFO read is issued.
  - Otherwise go to READ.
- READ, reads:
  - fifo_rxen = (state==READ) && !fifo_empty && (rd_cnt < len).
  - rd_cnt increments on each rxen.
  - rd_vld is rxen delayed by one cycle. On rd_vld, the byte is captured at index wr_idx and wr_idx increments.
- READ, per-byte handling:
  - wr_idx 0..1: compare against HDR. hdr_ok is cleared on the first mismatch.
  - wr_idx 2..len-2: fold the byte into the accumulator (acc+byte mod 256, or acc^byte). Indices 2..NCMD+1 go to the cmd_out shadow register.
  - wr_idx len-1: stored as the received checksum; it is not accumulated.
- READ, exits:
  - A header mismatch does not abort the frame. The remaining bytes are still drained so the FIFO stays frame-aligned.
  - Timeout counter: reset on each rd_vld and incremented otherwise. When it reaches TIMEOUT, go to DONE with err_code=4. Bytes already read are discarded and the next in-flight rd_vld is ignored.
  - When wr_idx==len (all bytes captured), go to CHECK.
- CHECK (1 cycle): priority is header (1), then checksum (2), then ok (0).
- Entry to DONE:
  - ok: cmd_out <= shadow, cmd_valid pulses, frame_cnt++.
  - Error: cmd_out <= all ones, err=1, err_cnt++.
  - cmd_out holds its value until the next frame's DONE entry.
- DONE: fd=1; stay until fs=0, then go to IDLE. err and err_code hold until the next LOAD, which clears them.
- Latency: fd rises 2 cycles after the edge that captures the last byte. With the FIFO never empty, fd rises len+4 cycles after the edge at which IDLE samples fs=1.
- fs dropping mid-frame is ignored; the frame completes. A new fs is honoured only from IDLE.
- Reset mid-frame returns everything to reset values immediately. The partially read frame is lost; the upstream FIFO is not flushed by this block.
- Counters saturate and never wrap.

Test Plan:
- Good frame, sum mode, len=12, FIFO never empty:
  - Stimulus: bytes 55 AA 01 02 03 04 05 06 07 08 09 2D.
  - Response: cmd_out=72'h010203040506070809, err=0, err_code=0, cmd_valid pulses once, frame_cnt=1, fd rises 16 cycles after fs is sampled.
- Header error:
  - Stimulus: same frame with byte0=0x54.
  - Response: all 12 bytes are read (12 rxen pulses), err_code=1, cmd_out all ones, err_cnt=1, no cmd_valid.
- Checksum error:
  - Stimulus: last byte 0x2C.
  - Response: err_code=2, cmd_out all ones.
  - Then send the good frame: cmd_out=72'h010203040506070809, frame_cnt=2.
- Flow control:
  - Stimulus: fifo_empty toggles 3 cycles high / 1 low during the good frame.
  - Response: rxen never asserts while empty, result identical to the good-frame case.
- Timeout and length:
  - Stimulus: TIMEOUT=8 with fifo_empty stuck high after 5 bytes.
  - Response: err_code=4, fd rises 9 cycles after the 5th byte is captured.
  - Stimulus: data_len=11 (below NCMD+3).
  - Response: err_code=3, zero rxen pulses.
- CHK_XOR=1 and reset abort:
  - Stimulus: CHK_XOR=1 with checksum byte 0x01.
  - Response: frame passes.
  - Stimulus: rst asserted at byte 6 of a frame.
  - Response: all outputs 0, state IDLE; the next frame parses correctly.
